uart_tx_frame: RTL and testbench



---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_baud_tick.sv | 39 +++
 rtl/uart_tx_frame.sv | 159 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line FSM states, default clocking
// constants and the bit-period helper used by both TX and RX.
package uart_pkg;

    localparam int unsigned UART_CLK_FREQ  = 100_000_000;
    localparam int unsigned UART_BAUD_RATE = 460_800;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clocks per bit, truncating like the receiver does.
    function automatic int unsigned clks_per_bit(
        input int unsigned clk_freq,
        input int unsigned baud_rate
    );
        return clk_freq / baud_rate;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than 1.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick on the last clock of each bit.
// Cleared by the owning FSM while idle; shared with the receiver.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    // Wrap on the tick so every bit boundary restarts the count.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: one byte per valid/ready handshake, sent as
// start + LSB-first data + stop. `UART_TX_PARITY_EN adds even parity.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = UART_CLK_FREQ,
    parameter int unsigned BAUD_RATE = UART_BAUD_RATE,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [DATA_BITS-1:0] tx_din,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_data
);

    localparam int unsigned CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned BCW   = cnt_width(DATA_BITS);
    localparam logic [BCW-1:0] DATA_LAST = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    uart_state_e          state_q;
    uart_state_e          state_d;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] shift_d;
    logic [BCW-1:0]       bit_q;
    logic [BCW-1:0]       bit_d;
    logic                 tx_data_q;
    logic                 tx_data_d;
    logic                 busy_q;
    logic                 busy_d;
    logic                 ready_q;
    logic                 ready_d;
    logic                 tick;
`ifdef UART_TX_PARITY_EN
    logic                 par_q;
    logic                 par_d;
`endif

    assign tx_data  = tx_data_q;
    assign tx_busy  = busy_q;
    assign tx_ready = ready_q;

    uart_baud_tick #(
        .CLKS_PER_BIT (CPB)
    ) u_baud (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .clr  (state_q == ST_IDLE),
        .tick (tick)
    );

    // Next-state, shift and bit-count logic.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (tx_valid && ready_q) begin
                    shift_d = tx_din;
                    bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^tx_din;
`endif
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Line level and status flags decoded from the next state so
    // that all outputs come straight from flops.
    always_comb begin
        tx_data_d = 1'b1;
        unique case (state_d)
            ST_START: tx_data_d = 1'b0;
            ST_DATA:  tx_data_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_data_d = par_d;
`endif
            default:  tx_data_d = 1'b1;
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            tx_data_q <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
`ifdef UART_TX_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: default-rate DUT plus a
// 115200-baud DUT; checks line timing, handshake and reset.
module tb_uart_tx_frame;

    localparam int unsigned CPB   = 217;
    localparam int unsigned CPB_S = 868;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    localparam int unsigned NBITS = 1 + 8 + PB + 1;
    localparam int unsigned FRAME = NBITS * CPB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       valid = 1'b0;
    logic       ready, busy, line;
    logic [7:0] din_s = 8'h00;
    logic       valid_s = 1'b0;
    logic       ready_s, busy_s, line_s;

    int unsigned cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    logic [7:0]  rx_q[$];
    int unsigned fall_q[$];

    uart_tx_frame dut (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .tx_din   (din),
        .tx_valid (valid),
        .tx_ready (ready),
        .tx_busy  (busy),
        .tx_data  (line)
    );

    uart_tx_frame #(
        .CLK_FREQ  (100_000_000),
        .BAUD_RATE (115200)
    ) dut_s (
        .sys_clk  (clk),
        .sys_rst  (rst),
        .tx_din   (din_s),
        .tx_valid (valid_s),
        .tx_ready (ready_s),
        .tx_busy  (busy_s),
        .tx_data  (line_s)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    // Present a byte and return the cycle count just after the
    // accepting edge; drops valid one cycle later.
    task automatic send(input bit slow, input logic [7:0] b,
                        output int unsigned hs);
        int n;
        n = 0;
        @(negedge clk);
        if (slow) begin din_s = b; valid_s = 1'b1; end
        else begin din = b; valid = 1'b1; end
        while ((slow ? ready_s : ready) !== 1'b1 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("handshake_timeout", 32'(n < 20000), 32'd1);
        hs = cyc + 1;
        @(negedge clk);
        valid = 1'b0;
        valid_s = 1'b0;
    endtask

    // Check first and last cycle of every bit, then the ready edge.
    task automatic check_frame(input bit slow, input logic [7:0] b,
                               input int unsigned hs,
                               input int unsigned cpb,
                               input string tag);
        logic [NBITS-1:0] fb;
        int unsigned t;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        fb[9] = ^b;
`endif
        for (int k = 0; k < NBITS; k++) begin
            t = hs + k * cpb;
            wait_cyc(t);
            chk($sformatf("%s_bit%0d_first", tag, k),
                32'(slow ? line_s : line), 32'(fb[k]));
            wait_cyc(t + cpb - 1);
            chk($sformatf("%s_bit%0d_last", tag, k),
                32'(slow ? line_s : line), 32'(fb[k]));
        end
        chk({tag, "_ready_before_end"},
            32'(slow ? ready_s : ready), 32'd0);
        wait_cyc(hs + NBITS * cpb);
        chk({tag, "_ready_after_end"},
            32'(slow ? ready_s : ready), 32'd1);
        chk({tag, "_busy_after_end"},
            32'(slow ? busy_s : busy), 32'd0);
    endtask

    // Reference receiver on the default-rate line: mid-bit sampling.
    initial begin : rx_model
        logic [7:0] b;
        logic prev;
        prev = 1'b1;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && line === 1'b0) begin
                fall_q.push_back(cyc);
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = line;
                end
                repeat ((1 + PB) * CPB) @(negedge clk);
                if (line === 1'b1) rx_q.push_back(b);
            end
            prev = line;
        end
    end

    initial begin : stim
        int unsigned hs, hs2;

        repeat (3) @(negedge clk);
        chk("rst_line", 32'(line), 32'd1);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_line_s", 32'(line_s), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0x35.
        send(1'b0, 8'h35, hs);
        check_frame(1'b0, 8'h35, hs, CPB, "single");
        repeat (CPB) @(negedge clk);
        chk("single_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("single_rx_byte", 32'(rx_q[0]), 32'h35);
        rx_q.delete();
        fall_q.delete();

        // Back-to-back 0xA5, 0x5A with valid held.
        @(negedge clk);
        din = 8'hA5;
        valid = 1'b1;
        hs = cyc + 1;
        @(negedge clk);
        din = 8'h5A;
        check_frame(1'b0, 8'hA5, hs, CPB, "b2b0");
        hs2 = cyc + 1;
        @(negedge clk);
        valid = 1'b0;
        check_frame(1'b0, 8'h5A, hs2, CPB, "b2b1");
        repeat (CPB) @(negedge clk);
        chk("b2b_fall_count", 32'(fall_q.size()), 32'd2);
        chk("b2b_rx_count", 32'(rx_q.size()), 32'd2);
        if (fall_q.size() >= 2)
            chk("b2b_period", fall_q[1] - fall_q[0], FRAME);
        if (rx_q.size() >= 2) begin
            chk("b2b_rx0", 32'(rx_q[0]), 32'hA5);
            chk("b2b_rx1", 32'(rx_q[1]), 32'h5A);
        end
        rx_q.delete();
        fall_q.delete();

        // Busy rejection and tx_din change mid-frame.
        send(1'b0, 8'hC3, hs);
        wait_cyc(hs + 500);
        chk("busy_ready_low", 32'(ready), 32'd0);
        din = 8'hFF;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        din = 8'h00;
        wait_cyc(hs + FRAME + 600);
        chk("busy_fall_count", 32'(fall_q.size()), 32'd1);
        chk("busy_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("busy_rx_byte", 32'(rx_q[0]), 32'hC3);
        chk("busy_idle_after", 32'(busy), 32'd0);

        // Reset during data bit 3, with valid asserted alongside.
        send(1'b0, 8'h96, hs);
        wait_cyc(hs + 4 * CPB + 30);
        chk("mid_busy_before_rst", 32'(busy), 32'd1);
        rst = 1'b1;
        din = 8'hAA;
        valid = 1'b1;
        @(negedge clk);
        chk("midrst_line", 32'(line), 32'd1);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid_no_accept", 32'(busy), 32'd0);
        chk("rst_valid_line_high", 32'(line), 32'd1);
        wait_cyc(hs + FRAME + 400);
        rx_q.delete();
        fall_q.delete();
        send(1'b0, 8'h0F, hs);
        check_frame(1'b0, 8'h0F, hs, CPB, "after_rst");
        repeat (CPB) @(negedge clk);
        chk("after_rst_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("after_rst_rx", 32'(rx_q[0]), 32'h0F);
        rx_q.delete();
        fall_q.delete();

        // 115200 baud: alternating bits pin every bit width to 868.
        send(1'b1, 8'h55, hs);
        check_frame(1'b1, 8'h55, hs, CPB_S, "slow");

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 -> 1, 0x03 -> 0; period grows by a bit.
        rx_q.delete();
        fall_q.delete();
        @(negedge clk);
        din = 8'h07;
        valid = 1'b1;
        hs = cyc + 1;
        @(negedge clk);
        din = 8'h03;
        check_frame(1'b0, 8'h07, hs, CPB, "par07");
        hs2 = cyc + 1;
        @(negedge clk);
        valid = 1'b0;
        check_frame(1'b0, 8'h03, hs2, CPB, "par03");
        repeat (CPB) @(negedge clk);
        chk("par_fall_count", 32'(fall_q.size()), 32'd2);
        if (fall_q.size() >= 2)
            chk("par_period", fall_q[1] - fall_q[0], 32'd2388);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
